// File: rtl/seq_multiplier_pkg.sv
// Shared CPU definitions: ALU operation codes, ALUOp codes, word width and
// the state encoding used by the iterative multiplier.
package seq_multiplier_pkg;

  localparam int WORD_WIDTH = 24;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SLT = 4'b0011;
  localparam logic [3:0] OP_MUL = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_SLL = 4'b0110;

  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_MUL   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } mul_state_e;

endpackage

// File: rtl/seq_multiplier_datapath.sv
// Shift-add datapath: multiplicand register, {accumulator, multiplier} shift pair
// and a WIDTH+1-bit adder. Exposes the post-step product so the caller can capture it.
module mul_datapath
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] prod_hi_nxt,
  output logic [WIDTH-1:0] prod_lo_nxt
);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH:0]   sum;

  always_comb begin
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    // Carry kept in sum[WIDTH] and shifted back into the accumulator MSB.
    sum = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    if (load) begin
      mcand_d  = a;
      acc_d    = '0;
      mplier_d = b;
    end else if (step) begin
      acc_d    = sum[WIDTH:1];
      mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
    end
  end

  assign prod_hi_nxt = acc_d;
  assign prod_lo_nxt = mplier_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
    end else begin
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
    end
  end

endmodule

// File: rtl/seq_multiplier.sv
// Iterative unsigned multiplier for the MUL ALU operation: WIDTH-cycle fixed latency,
// Busy while running, one-cycle Done when the registered product is valid.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int         WIDTH  = WORD_WIDTH,
  parameter logic [3:0] MUL_OP = OP_MUL
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [3:0]       Operation,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] ResultHi,
  output logic             Overflow,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  mul_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic             ovf_q, ovf_d;
  logic             accept, load, step;
  logic [WIDTH-1:0] prod_hi_nxt, prod_lo_nxt;

  // Start is honoured in DONE as well as IDLE so results can issue back-to-back.
  assign accept = Start && (Operation == MUL_OP) && (state_q != RUN);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    ovf_d    = ovf_q;
    load     = 1'b0;
    step     = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        step  = 1'b1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d  = DONE;
          res_lo_d = prod_lo_nxt;
          res_hi_d = prod_hi_nxt;
          ovf_d    = |prod_hi_nxt;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      ovf_q    <= ovf_d;
    end
  end

  mul_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk         (Clock),
    .rst         (Reset),
    .load        (load),
    .step        (step),
    .a           (A),
    .b           (B),
    .prod_hi_nxt (prod_hi_nxt),
    .prod_lo_nxt (prod_lo_nxt)
  );

  assign Result   = res_lo_q;
  assign ResultHi = res_hi_q;
  assign Overflow = ovf_q;
  assign Busy     = (state_q == RUN);
  assign Done     = (state_q == DONE);

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: latency, handshake, arithmetic corners and reset.
module tb_seq_multiplier;
  localparam int W = 24;

  logic         Clock = 1'b0;
  logic         Reset;
  logic         Start;
  logic [3:0]   Operation;
  logic [W-1:0] A, B;
  logic [W-1:0] Result, ResultHi;
  logic         Overflow, Busy, Done;

  int errors = 0;
  int checks = 0;

  seq_multiplier dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Operation(Operation),
    .A(A), .B(B), .Result(Result), .ResultHi(ResultHi),
    .Overflow(Overflow), .Busy(Busy), .Done(Done)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Drives one accept edge (edge 0); returns in the cycle after it.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    Start = 1'b1; Operation = 4'b0100; A = a; B = b;
    tick();
    Start = 1'b0; A = '0; B = '0;
  endtask

  // Counts edges until Done, with busy cycles observed on the way; bounded.
  task automatic wait_done(input int already, output int n, output int busy_n);
    n = already;
    busy_n = already;
    while (!Done && n < 60) begin
      if (Busy) busy_n++;
      tick();
      n++;
    end
  endtask

  task automatic expect_product(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] lo, input logic [W-1:0] hi, input logic ovf);
    int n, bn;
    issue(a, b);
    wait_done(0, n, bn);
    chk({tag, "_latency"}, n, 24);
    chk({tag, "_busy"}, bn, 24);
    chk({tag, "_lo"}, Result, lo);
    chk({tag, "_hi"}, ResultHi, hi);
    chk({tag, "_ovf"}, Overflow, ovf);
    tick();
    chk({tag, "_done_pulse"}, Done, 0);
  endtask

  initial begin
    int n, bn, dcnt;
    Reset = 1'b1; Start = 1'b0; Operation = 4'b0000; A = '0; B = '0;
    tick(); tick();
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_result", {ResultHi, Result, 7'd0, Overflow}, 0);
    Reset = 1'b0;
    tick();

    expect_product("basic", 24'd3, 24'd5, 24'd15, 24'd0, 1'b0);
    expect_product("full", 24'hFFFFFF, 24'hFFFFFF, 24'h000001, 24'hFFFFFE, 1'b1);

    // Wrong operation code is ignored; previous result held.
    Start = 1'b1; Operation = 4'b0010; A = 24'd7; B = 24'd9;
    tick();
    Start = 1'b0;
    chk("wrongop_busy", Busy, 0);
    dcnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (Done || Busy) dcnt++;
      tick();
    end
    chk("wrongop_activity", dcnt, 0);
    chk("wrongop_hold_lo", Result, 24'h000001);
    chk("wrongop_hold_hi", ResultHi, 24'hFFFFFE);

    expect_product("zero", 24'd0, 24'd123456, 24'd0, 24'd0, 1'b0);
    expect_product("carry", 24'h800000, 24'd2, 24'd0, 24'd1, 1'b1);
    expect_product("ffx2", 24'hFFFFFF, 24'd2, 24'hFFFFFE, 24'd1, 1'b1);

    // Start while busy must not re-latch or restart.
    issue(24'd2, 24'd3);
    for (int i = 0; i < 9; i++) tick();
    Start = 1'b1; Operation = 4'b0100; A = 24'd100; B = 24'd100;
    tick();
    Start = 1'b0;
    wait_done(10, n, bn);
    chk("busystart_latency", n, 24);
    chk("busystart_result", Result, 24'd6);
    tick();
    dcnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (Done) dcnt++;
      tick();
    end
    chk("busystart_extra_done", dcnt, 0);

    // Back-to-back issue from the DONE cycle.
    issue(24'd7, 24'd6);
    wait_done(0, n, bn);
    chk("b2b_first_done", Done, 1);
    chk("b2b_first_result", Result, 24'd42);
    issue(24'd10, 24'd10);
    chk("b2b_busy", Busy, 1);
    chk("b2b_hold_in_run", Result, 24'd42);
    wait_done(0, n, bn);
    chk("b2b_latency", n, 24);
    chk("b2b_result", Result, 24'd100);
    tick();

    // Reset mid-operation: immediate clear, no late Done.
    issue(24'd4, 24'd4);
    for (int i = 0; i < 11; i++) tick();
    chk("midrst_pre_busy", Busy, 1);
    Reset = 1'b1;
    #1;
    chk("midrst_busy", Busy, 0);
    chk("midrst_done", Done, 0);
    chk("midrst_result", Result, 0);
    tick();
    Reset = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (Done || Busy) dcnt++;
      tick();
    end
    chk("midrst_no_done", dcnt, 0);
    expect_product("after_rst", 24'd4, 24'd4, 24'd16, 24'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
